// File: rtl/quad_enc_decoder_if.sv
// Quadrature encoder decoder bundle: raw encoder channels and controls in, position/velocity status out.
// master drives the encoder side; slave is the decoder.
interface quad_enc_decoder_if #(
  parameter int POS_W = 14,
  parameter int VEL_W = 16
);
  logic             a_in;
  logic             b_in;
  logic             z_in;
  logic             zero_req;
  logic             index_home_en;
  logic [POS_W-1:0] pos;
  logic [POS_W-3:0] pos_coarse;
  logic             pos_valid;
  logic             step_pulse;
  logic             dir;
  logic             illegal;
  logic             index_seen;
  logic             stalled;
  logic [VEL_W-1:0] period;
  logic [7:0]       err_cnt;

  modport master (
    output a_in, b_in, z_in, zero_req, index_home_en,
    input  pos, pos_coarse, pos_valid, step_pulse, dir, illegal,
    input  index_seen, stalled, period, err_cnt
  );

  modport slave (
    input  a_in, b_in, z_in, zero_req, index_home_en,
    output pos, pos_coarse, pos_valid, step_pulse, dir, illegal,
    output index_seen, stalled, period, err_cnt
  );
endinterface

// File: rtl/quad_enc_decoder.sv
// Quadrature A/B(/Z) decoder: sync + glitch filter, x4 position, step period and error count; QDEC_INDEX_EN adds Z homing.
// Input change to pos/step_pulse is FILT_CYCLES+3 cycles; no backpressure, outputs update every cycle.
module quad_enc_decoder #(
  parameter int CPR         = 4096,
  parameter int POS_W       = 14,
  parameter int FILT_CYCLES = 2,
  parameter int VEL_W       = 16,
  parameter bit INVERT_A    = 1'b0,
  parameter bit INVERT_B    = 1'b0,
  parameter bit INVERT_Z    = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  quad_enc_decoder_if.slave enc
);

`ifdef QDEC_INDEX_EN
  localparam int NCH = 3;
`else
  localparam int NCH = 2;
`endif

  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(4 * CPR - 1);
  localparam logic [VEL_W-1:0] AGE_MAX   = '1;
  localparam logic [7:0]       FILT_LAST = 8'(FILT_CYCLES);
  localparam logic [8:0]       WU_LAST   = 9'(FILT_CYCLES + 2);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] inv;
  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sync2_q;
  logic [NCH-1:0] filt;

`ifdef QDEC_INDEX_EN
  assign raw = {enc.z_in, enc.b_in, enc.a_in};
  assign inv = {INVERT_Z, INVERT_B, INVERT_A};
`else
  assign raw = {enc.b_in, enc.a_in};
  assign inv = {INVERT_B, INVERT_A};
  logic unused_index;
  assign unused_index = enc.z_in ^ enc.index_home_en ^ INVERT_Z;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw ^ inv;
      sync2_q <= sync1_q;
    end
  end

  // The accepted level is visible combinationally in the cycle the last required sample arrives.
  for (genvar i = 0; i < NCH; i++) begin : g_filt
    logic [7:0] cnt_q, cnt_d;
    logic       lvl_q, lvl_d;

    always_comb begin
      lvl_d = lvl_q;
      cnt_d = 8'd0;
      if (sync2_q[i] != lvl_q) begin
        if (cnt_q == FILT_LAST) begin
          lvl_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end

    assign filt[i] = lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= 8'd0;
        lvl_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end
  end

  logic [1:0]       cur_ab;
  logic [1:0]       prev_q, prev_d;
  logic             primed_q, primed_d;
  logic [8:0]       wu_q, wu_d;
  logic             valid_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             step_q;
  logic             illegal_q;
  logic             seen_q, seen_d;
  logic [7:0]       err_q, err_d;
  logic [VEL_W-1:0] age_q, age_d;
  logic [VEL_W-1:0] period_q, period_d;
  logic             stalled_q, stalled_d;
  logic             cw, acw, step, bad, home;

  assign cur_ab = {filt[0], filt[1]};

  always_comb begin
    cw  = 1'b0;
    acw = 1'b0;
    case ({prev_q, cur_ab})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: cw  = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: acw = 1'b1;
      default: ;
    endcase
  end

  assign step = primed_q & (cw | acw);
  assign bad  = primed_q & ((prev_q ^ cur_ab) == 2'b11);

`ifdef QDEC_INDEX_EN
  logic z_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_prev_q <= 1'b0;
    end else begin
      z_prev_q <= filt[2];
    end
  end

  assign home = filt[2] & ~z_prev_q & enc.index_home_en;
`else
  assign home = 1'b0;
`endif

  always_comb begin
    prev_d    = prev_q;
    primed_d  = primed_q;
    wu_d      = wu_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    seen_d    = seen_q;
    err_d     = err_q;
    age_d     = age_q;
    period_d  = period_q;
    stalled_d = stalled_q;

    // Seed only once the pipeline holds real input data, so a resting encoder never looks like a jump.
    if (!primed_q) begin
      if (wu_q == WU_LAST) begin
        prev_d   = cur_ab;
        primed_d = 1'b1;
      end else begin
        wu_d = wu_q + 9'd1;
      end
    end else begin
      prev_d = cur_ab;
    end

    if (step) begin
      dir_d = cw;
      if (cw) begin
        pos_d = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
      end else begin
        pos_d = (pos_q == '0) ? POS_MAX : pos_q - 1'b1;
      end
    end

    if (bad && err_q != 8'hFF) begin
      err_d = err_q + 8'd1;
    end

    if (home) begin
      pos_d  = '0;
      seen_d = 1'b1;
    end

    if (enc.zero_req) begin
      pos_d  = '0;
      seen_d = 1'b0;
      err_d  = 8'd0;
    end

    if (step) begin
      age_d     = '0;
      period_d  = (age_q == AGE_MAX) ? AGE_MAX : age_q + 1'b1;
      stalled_d = 1'b0;
    end else if (age_q == AGE_MAX) begin
      period_d  = AGE_MAX;
      stalled_d = 1'b1;
    end else begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= 2'b00;
      primed_q  <= 1'b0;
      wu_q      <= 9'd0;
      valid_q   <= 1'b0;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
      illegal_q <= 1'b0;
      seen_q    <= 1'b0;
      err_q     <= 8'd0;
      age_q     <= '0;
      period_q  <= '0;
      stalled_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      wu_q      <= wu_d;
      valid_q   <= primed_q;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      step_q    <= step;
      illegal_q <= bad;
      seen_q    <= seen_d;
      err_q     <= err_d;
      age_q     <= age_d;
      period_q  <= period_d;
      stalled_q <= stalled_d;
    end
  end

  assign enc.pos        = pos_q;
  assign enc.pos_coarse = pos_q[POS_W-1:2];
  assign enc.pos_valid  = valid_q;
  assign enc.step_pulse = step_q;
  assign enc.dir        = dir_q;
  assign enc.illegal    = illegal_q;
  assign enc.index_seen = seen_q;
  assign enc.stalled    = stalled_q;
  assign enc.period     = period_q;
  assign enc.err_cnt    = err_q;

endmodule
